tetris_playfield: RTL and testbench

Parametrised playfield engine for the Tetris datapath. It holds a WIDTH×HEIGHT locked-cell grid and one falling piece described by a 4×4 mask. It applies left/right moves and gravity ticks with wall and stack collision checks, locks the piece, clears full rows one row per cycle, and requests the next piece. It sits between the input/timing logic (button pulses, gravity tick) and the VGA renderer, which consumes `grid_out`.

---
 rtl/tetris_playfield.sv | 224 ++++++++++++++++++++++
 tb/tb_tetris_playfield.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_playfield.sv
// Tetris playfield engine: locked grid, one falling 4x4 piece, collision checks, lock, line clear.
// Optional rotation is compiled in when TETRIS_ROTATE_EN is defined.
module tetris_playfield #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned HEIGHT  = 20,
    parameter int unsigned LINES_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      move_left,
    input  logic                      move_right,
    input  logic                      rotate,
    input  logic                      restart,
    input  logic [15:0]               piece_mask,
    input  logic                      piece_valid,
    output logic                      piece_ready,
    output logic [WIDTH*HEIGHT-1:0]   grid_out,
    output logic [LINES_W-1:0]        lines_cleared,
    output logic                      game_over
);

    localparam int unsigned N   = WIDTH * HEIGHT;
    localparam int unsigned IW  = $clog2(N + 1);
    localparam int unsigned SRW = $clog2(HEIGHT);

    typedef enum logic [2:0] {
        StSpawn,
        StCheck,
        StFall,
        StLock,
        StClear,
        StOver
    } state_e;

    state_e                  state_q;
    logic [N-1:0]            grid_q;
    logic [15:0]             mask_q;
    logic signed [7:0]       px_q;
    logic signed [7:0]       py_q;
    logic                    tick_pend_q;
    logic [SRW-1:0]          sr_q;
    logic [LINES_W-1:0]      lines_q;

    // Returns the piece footprint on the grid; bit N flags any cell outside the field.
    // Out-of-range origins are flagged even for an empty mask so a zero piece still lands.
    function automatic logic [N:0] place(input logic [15:0] m,
                                         input logic signed [7:0] x,
                                         input logic signed [7:0] y);
        logic [N:0] res;
        int         r;
        int         c;
        res = '0;
        if (int'(y) >= int'(HEIGHT) || int'(x) < -3 || int'(x) >= int'(WIDTH)) begin
            res[N] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (m[4'(i * 4 + j)]) begin
                    r = int'(y) + i;
                    c = int'(x) + j;
                    if (r < 0 || r >= int'(HEIGHT) || c < 0 || c >= int'(WIDTH)) begin
                        res[N] = 1'b1;
                    end else begin
                        res[IW'(r * int'(WIDTH) + c)] = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    logic signed [7:0] px_left;
    logic signed [7:0] px_right;
    logic signed [7:0] py_down;
    logic [N:0]        p_cur;
    logic [N:0]        p_left;
    logic [N:0]        p_right;
    logic [N:0]        p_down;
    logic              hit_cur;
    logic              hit_left;
    logic              hit_right;
    logic              hit_down;

    assign px_left  = px_q - 8'sd1;
    assign px_right = px_q + 8'sd1;
    assign py_down  = py_q + 8'sd1;

    always_comb begin
        p_cur   = place(mask_q, px_q, py_q);
        p_left  = place(mask_q, px_left, py_q);
        p_right = place(mask_q, px_right, py_q);
        p_down  = place(mask_q, px_q, py_down);
    end

    assign hit_cur   = p_cur[N]   | (|(p_cur[N-1:0]   & grid_q));
    assign hit_left  = p_left[N]  | (|(p_left[N-1:0]  & grid_q));
    assign hit_right = p_right[N] | (|(p_right[N-1:0] & grid_q));
    assign hit_down  = p_down[N]  | (|(p_down[N-1:0]  & grid_q));

`ifdef TETRIS_ROTATE_EN
    logic [15:0] rot_mask;
    logic [N:0]  p_rot;
    logic        hit_rot;

    // Clockwise about the fixed 4x4 box: new[i][j] = old[3-j][i].
    always_comb begin
        rot_mask = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                rot_mask[4'(i * 4 + j)] = mask_q[4'((3 - j) * 4 + i)];
            end
        end
        p_rot = place(rot_mask, px_q, py_q);
    end

    assign hit_rot = p_rot[N] | (|(p_rot[N-1:0] & grid_q));
`else
    logic unused_rotate;
    assign unused_rotate = rotate;
`endif

    logic [HEIGHT-1:0] row_full;
    logic [N-1:0]      keep_rows;
    logic [N-1:0]      grid_shift;

    // Rows above and including sr take the row above them; rows below sr are kept.
    always_comb begin
        row_full  = '0;
        keep_rows = '0;
        for (int r = 0; r < int'(HEIGHT); r++) begin
            row_full[r] = &grid_q[r * WIDTH +: WIDTH];
            keep_rows[r * WIDTH +: WIDTH] = (r <= int'(sr_q)) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
        grid_shift = ((grid_q << WIDTH) & ~keep_rows) | (grid_q & keep_rows);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StSpawn;
            grid_q      <= '0;
            mask_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            tick_pend_q <= 1'b0;
            sr_q        <= '0;
            lines_q     <= '0;
        end else begin
            if (tick) begin
                tick_pend_q <= 1'b1;
            end
            unique case (state_q)
                StSpawn: begin
                    if (piece_valid) begin
                        mask_q  <= piece_mask;
                        px_q    <= 8'((WIDTH - 4) / 2);
                        py_q    <= '0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    state_q <= hit_cur ? StOver : StFall;
                end
                StFall: begin
                    // A single move request owns the cycle even when rejected; ticks wait.
                    if (move_left ^ move_right) begin
                        if (move_left && !hit_left) begin
                            px_q <= px_left;
                        end else if (move_right && !hit_right) begin
                            px_q <= px_right;
                        end
                    end
`ifdef TETRIS_ROTATE_EN
                    else if (rotate) begin
                        if (!hit_rot) begin
                            mask_q <= rot_mask;
                        end
                    end
`endif
                    else if (tick_pend_q) begin
                        tick_pend_q <= tick;
                        if (hit_down) begin
                            state_q <= StLock;
                        end else begin
                            py_q <= py_down;
                        end
                    end
                end
                StLock: begin
                    grid_q  <= grid_q | p_cur[N-1:0];
                    sr_q    <= SRW'(HEIGHT - 1);
                    state_q <= StClear;
                end
                StClear: begin
                    if (row_full[sr_q]) begin
                        grid_q  <= grid_shift;
                        lines_q <= lines_q + LINES_W'(1);
                    end else if (sr_q == '0) begin
                        state_q <= StSpawn;
                    end else begin
                        sr_q <= sr_q - SRW'(1);
                    end
                end
                StOver: begin
                    if (restart) begin
                        grid_q      <= '0;
                        lines_q     <= '0;
                        tick_pend_q <= 1'b0;
                        state_q     <= StSpawn;
                    end
                end
                default: begin
                    state_q <= StSpawn;
                end
            endcase
        end
    end

    assign piece_ready   = (state_q == StSpawn);
    assign game_over     = (state_q == StOver);
    assign lines_cleared = lines_q;
    assign grid_out      = grid_q | ((state_q == StFall) ? p_cur[N-1:0] : {N{1'b0}});

endmodule

// File: tb/tb_tetris_playfield.sv
// Directed self-checking bench for tetris_playfield at WIDTH=10, HEIGHT=20.
module tb_tetris_playfield;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          move_left = 1'b0;
    logic          move_right = 1'b0;
    logic          rotate = 1'b0;
    logic          restart = 1'b0;
    logic [15:0]   piece_mask = 16'h0;
    logic          piece_valid = 1'b0;
    logic          piece_ready;
    logic [N-1:0]  grid_out;
    logic [15:0]   lines_cleared;
    logic          game_over;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    tetris_playfield #(.WIDTH(W), .HEIGHT(H), .LINES_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .rotate        (rotate),
        .restart       (restart),
        .piece_mask    (piece_mask),
        .piece_valid   (piece_valid),
        .piece_ready   (piece_ready),
        .grid_out      (grid_out),
        .lines_cleared (lines_cleared),
        .game_over     (game_over)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] rows(input int r0, input int r1, input logic [W-1:0] v);
        logic [N-1:0] g;
        g = '0;
        for (int r = r0; r <= r1; r++) g[r*W +: W] = v;
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic spawn(input logic [15:0] m);
        int n;
        n = 0;
        while (!piece_ready && n < 100) begin
            step();
            n++;
        end
        vecs++;
        if (piece_ready !== 1'b1) begin
            errs++;
            $display("FAIL spawn_wait: piece_ready=%b required 1", piece_ready);
        end
        piece_mask  = m;
        piece_valid = 1'b1;
        step();
        piece_valid = 1'b0;
        step();
    endtask

    task automatic pulse_left(input int n);
        repeat (n) begin
            move_left = 1'b1;
            step();
            move_left = 1'b0;
        end
    endtask

    task automatic pulse_right(input int n);
        repeat (n) begin
            move_right = 1'b1;
            step();
            move_right = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    // The last tick locks the piece; cyc counts edges from entering LOCK to piece_ready.
    task automatic drop(input int n, output int cyc);
        ticks(n);
        cyc = 0;
        while (!piece_ready && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        vecs++;
        if (piece_ready !== 1'b1 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL async_reset_state: ready=%b over=%b required 1 0", piece_ready, game_over);
        end
        vecs++;
        if (grid_out !== '0 || lines_cleared !== 16'd0) begin
            errs++;
            $display("FAIL async_reset_grid: grid=%h lines=%0d required 0 0", grid_out, lines_cleared);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (piece_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: piece_ready=%b required 1", piece_ready);
        end
        vecs++;
        if (grid_out !== '0) begin
            errs++;
            $display("FAIL reset_grid: grid=%h required 0", grid_out);
        end
        vecs++;
        if (lines_cleared !== 16'd0 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL reset_misc: lines=%0d over=%b required 0 0", lines_cleared, game_over);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_ibar_drop();
        int cyc;
        spawn(16'h000F);
        vecs++;
        if (grid_out !== rows(0, 0, 10'h078)) begin
            errs++;
            $display("FAIL ibar_spawn: grid=%h required %h", grid_out, rows(0, 0, 10'h078));
        end
        ticks(19);
        vecs++;
        if (grid_out !== rows(19, 19, 10'h078)) begin
            errs++;
            $display("FAIL ibar_19_ticks: grid=%h required %h", grid_out, rows(19, 19, 10'h078));
        end
        drop(1, cyc);
        vecs++;
        if (cyc !== 21) begin
            errs++;
            $display("FAIL ibar_lock_latency: cycles=%0d required 21", cyc);
        end
        vecs++;
        if (grid_out !== rows(19, 19, 10'h078) || lines_cleared !== 16'd0) begin
            errs++;
            $display("FAIL ibar_locked: grid=%h lines=%0d required %h 0",
                     grid_out, lines_cleared, rows(19, 19, 10'h078));
        end
    endtask

    task automatic test_move_left();
        logic [N-1:0] base;
        base = rows(19, 19, 10'h078);
        spawn(16'h000F);
        pulse_left(5);
        vecs++;
        if (grid_out !== (base | rows(0, 0, 10'h00F))) begin
            errs++;
            $display("FAIL left_wall: grid=%h required %h", grid_out, base | rows(0, 0, 10'h00F));
        end
        move_left = 1'b1;
        tick      = 1'b1;
        step();
        move_left = 1'b0;
        tick      = 1'b0;
        vecs++;
        if (grid_out !== (base | rows(0, 0, 10'h00F))) begin
            errs++;
            $display("FAIL left_blocked: grid=%h required %h", grid_out, base | rows(0, 0, 10'h00F));
        end
        step();
        vecs++;
        if (grid_out !== (base | rows(1, 1, 10'h00F))) begin
            errs++;
            $display("FAIL deferred_tick: grid=%h required %h", grid_out, base | rows(1, 1, 10'h00F));
        end
    endtask

    task automatic test_line_clear();
        int cyc;
        apply_reset();
        spawn(16'h000F);
        pulse_left(3);
        drop(20, cyc);
        spawn(16'h0003);
        pulse_right(1);
        drop(20, cyc);
        spawn(16'h0007);
        pulse_right(4);
        drop(20, cyc);
        vecs++;
        if (grid_out !== rows(19, 19, 10'h3BF) || cyc !== 21) begin
            errs++;
            $display("FAIL row_gap: grid=%h cycles=%0d required %h 21",
                     grid_out, cyc, rows(19, 19, 10'h3BF));
        end
        spawn(16'h1111);
        pulse_right(3);
        vecs++;
        if (grid_out !== (rows(19, 19, 10'h3BF) | rows(0, 3, 10'h040))) begin
            errs++;
            $display("FAIL vbar_col6: grid=%h required %h",
                     grid_out, rows(19, 19, 10'h3BF) | rows(0, 3, 10'h040));
        end
        drop(17, cyc);
        vecs++;
        if (cyc !== 22) begin
            errs++;
            $display("FAIL single_clear_latency: cycles=%0d required 22", cyc);
        end
        vecs++;
        if (lines_cleared !== 16'd1) begin
            errs++;
            $display("FAIL single_clear_count: lines=%0d required 1", lines_cleared);
        end
        vecs++;
        if (grid_out !== rows(17, 19, 10'h040)) begin
            errs++;
            $display("FAIL single_clear_shift: grid=%h required %h", grid_out, rows(17, 19, 10'h040));
        end
    endtask

    task automatic test_double_clear();
        int cyc;
        apply_reset();
        spawn(16'h0033);
        pulse_left(3);
        drop(19, cyc);
        spawn(16'h0033);
        pulse_left(1);
        drop(19, cyc);
        spawn(16'h0033);
        pulse_right(1);
        drop(19, cyc);
        spawn(16'h0033);
        pulse_right(3);
        drop(19, cyc);
        vecs++;
        if (grid_out !== rows(18, 19, 10'h0FF)) begin
            errs++;
            $display("FAIL squares_stack: grid=%h required %h", grid_out, rows(18, 19, 10'h0FF));
        end
        spawn(16'h0033);
        pulse_right(5);
        drop(19, cyc);
        vecs++;
        if (cyc !== 23) begin
            errs++;
            $display("FAIL double_clear_latency: cycles=%0d required 23", cyc);
        end
        vecs++;
        if (lines_cleared !== 16'd2 || grid_out !== '0) begin
            errs++;
            $display("FAIL double_clear: lines=%0d grid=%h required 2 0", lines_cleared, grid_out);
        end
    endtask

    task automatic test_game_over();
        int cyc;
        spawn(16'h1111);
        drop(17, cyc);
        spawn(16'h1111);
        drop(13, cyc);
        spawn(16'h1111);
        drop(9, cyc);
        spawn(16'h1111);
        drop(5, cyc);
        spawn(16'h1111);
        drop(1, cyc);
        vecs++;
        if (grid_out !== rows(0, 19, 10'h008)) begin
            errs++;
            $display("FAIL column_full: grid=%h required %h", grid_out, rows(0, 19, 10'h008));
        end
        spawn(16'h1111);
        vecs++;
        if (game_over !== 1'b1 || piece_ready !== 1'b0) begin
            errs++;
            $display("FAIL over_entry: over=%b ready=%b required 1 0", game_over, piece_ready);
        end
        move_left   = 1'b1;
        tick        = 1'b1;
        piece_valid = 1'b1;
        step();
        move_left   = 1'b0;
        tick        = 1'b0;
        piece_valid = 1'b0;
        step();
        vecs++;
        if (grid_out !== rows(0, 19, 10'h008) || game_over !== 1'b1 || lines_cleared !== 16'd2) begin
            errs++;
            $display("FAIL over_hold: grid=%h over=%b lines=%0d required %h 1 2",
                     grid_out, game_over, lines_cleared, rows(0, 19, 10'h008));
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        vecs++;
        if (grid_out !== '0 || lines_cleared !== 16'd0) begin
            errs++;
            $display("FAIL restart_clear: grid=%h lines=%0d required 0 0", grid_out, lines_cleared);
        end
        vecs++;
        if (piece_ready !== 1'b1 || game_over !== 1'b0) begin
            errs++;
            $display("FAIL restart_state: ready=%b over=%b required 1 0", piece_ready, game_over);
        end
        spawn(16'h000F);
        step();
        vecs++;
        if (grid_out !== rows(0, 0, 10'h078)) begin
            errs++;
            $display("FAIL restart_tick_cleared: grid=%h required %h", grid_out, rows(0, 0, 10'h078));
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0] exp_rot;
`ifdef TETRIS_ROTATE_EN
        exp_rot = rows(0, 3, 10'h040);
`else
        exp_rot = rows(0, 0, 10'h078);
`endif
        apply_reset();
        spawn(16'h000F);
        rotate = 1'b1;
        step();
        rotate = 1'b0;
        vecs++;
        if (grid_out !== exp_rot) begin
            errs++;
            $display("FAIL rotate_ibar: grid=%h required %h", grid_out, exp_rot);
        end
        apply_reset();
        spawn(16'h1111);
        pulse_right(6);
        vecs++;
        if (grid_out !== rows(0, 3, 10'h200)) begin
            errs++;
            $display("FAIL right_wall: grid=%h required %h", grid_out, rows(0, 3, 10'h200));
        end
        rotate = 1'b1;
        step();
        rotate = 1'b0;
        vecs++;
        if (grid_out !== rows(0, 3, 10'h200)) begin
            errs++;
            $display("FAIL rotate_wall_reject: grid=%h required %h", grid_out, rows(0, 3, 10'h200));
        end
    endtask

    initial begin
        test_reset();
        test_ibar_drop();
        test_move_left();
        test_line_clear();
        test_double_clear();
        test_game_over();
        test_rotate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
